// File: rtl/incline_mon.sv
// Incline display monitor: picks live, block-average or peak-hold incline, scales it,
// optionally saturates to the LED width, and registers it with an update strobe.
module incline_mon #(
    parameter int IN_W     = 13,
    parameter int LED_W    = 8,
    parameter int SHIFT    = 1,
    parameter int AVG_LOG2 = 2,
    parameter bit SAT      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld,
    input  logic signed [IN_W-1:0] incline,
    input  logic [1:0]             mode,
    input  logic                   clr,
    output logic [LED_W-1:0]       LED,
    output logic                   led_vld,
    output logic                   sat
);

    typedef enum logic [1:0] {
        MODE_LIVE = 2'd0,
        MODE_AVG  = 2'd1,
        MODE_MAX  = 2'd2,
        MODE_MIN  = 2'd3
    } mode_e;

    localparam int SUM_W = IN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // Wide enough that shifted samples never wrap before the clamp compare.
    localparam int CW    = IN_W + LED_W + 1;
    localparam logic signed [CW-1:0] LED_MAX = (CW'(1) <<< (LED_W - 1)) - CW'(1);
    localparam logic signed [CW-1:0] LED_MIN = ~LED_MAX;

    mode_e                   mode_s;
    logic signed [SUM_W-1:0] sum_q, sum_d, sum_nx;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    win_last, win_done;
    logic signed [IN_W-1:0]  avg_new;
    logic signed [IN_W-1:0]  max_q, max_d, min_q, min_d;
    logic                    empty_q, empty_d;
    logic signed [IN_W-1:0]  v;
    logic                    upd;
    logic signed [CW-1:0]    s;
    logic [LED_W-1:0]        led_q, led_d;
    logic                    sat_q, sat_d;
    logic                    led_vld_q;

    assign mode_s = mode_e'(mode);

    always_comb begin
        sum_nx   = sum_q + SUM_W'(incline);
        win_last = (AVG_LOG2 == 0) || (cnt_q == '1);
        avg_new  = IN_W'(sum_nx >>> AVG_LOG2);
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        win_done = 1'b0;
        if (vld) begin
            if (win_last) begin
                sum_d    = '0;
                cnt_d    = '0;
                win_done = 1'b1;
            end else begin
                sum_d = sum_nx;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A sample arriving with clr reloads the peaks from that sample.
    always_comb begin
        max_d   = max_q;
        min_d   = min_q;
        empty_d = empty_q;
        if (vld) begin
            if (empty_q || clr) begin
                max_d = incline;
                min_d = incline;
            end else begin
                if (incline > max_q) max_d = incline;
                if (incline < min_q) min_d = incline;
            end
            empty_d = 1'b0;
        end else if (clr) begin
            empty_d = 1'b1;
        end
    end

    always_comb begin
        v   = incline;
        upd = 1'b0;
        unique case (mode_s)
            MODE_LIVE: begin v = incline; upd = vld;      end
            MODE_AVG:  begin v = avg_new; upd = win_done; end
            MODE_MAX:  begin v = max_d;   upd = vld;      end
            MODE_MIN:  begin v = min_d;   upd = vld;      end
            default:   begin v = incline; upd = 1'b0;     end
        endcase
    end

    always_comb begin
        s     = CW'(v) >>> SHIFT;
        led_d = s[LED_W-1:0];
        sat_d = 1'b0;
        if (SAT) begin
            if (s > LED_MAX) begin
                led_d = {1'b0, {(LED_W-1){1'b1}}};
                sat_d = 1'b1;
            end else if (s < LED_MIN) begin
                led_d = {1'b1, {(LED_W-1){1'b0}}};
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            empty_q   <= 1'b1;
            led_q     <= '0;
            sat_q     <= 1'b0;
            led_vld_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            empty_q   <= empty_d;
            led_vld_q <= upd;
            if (upd) begin
                led_q <= led_d;
                sat_q <= sat_d;
            end
        end
    end

    assign LED     = led_q;
    assign led_vld = led_vld_q;
    assign sat     = sat_q;

endmodule
